// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one cache read per cycle when the output
// FIFO has room, and pairs the one-cycle-late cache data with its PC.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    output logic [31:0] o_CacheAddress,
    input  logic [31:0] i_CacheData,
    input  logic        i_CacheAddressMisaligned,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectTarget,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [31:0] o_PC,
    output logic [31:0] o_Instruction,
    output logic        o_Exception
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_fault_q, inflight_fault_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   pc_mem_q  [FIFO_DEPTH];
    logic [31:0]   pc_mem_d  [FIFO_DEPTH];
    logic [31:0]   ins_mem_q [FIFO_DEPTH];
    logic [31:0]   ins_mem_d [FIFO_DEPTH];
    logic          exc_mem_q [FIFO_DEPTH];
    logic          exc_mem_d [FIFO_DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [AW:0]   occupancy;

    assign o_Valid        = (count_q != '0);
    assign o_PC           = o_Valid ? pc_mem_q[rd_ptr_q]  : 32'd0;
    assign o_Instruction  = o_Valid ? ins_mem_q[rd_ptr_q] : 32'd0;
    assign o_Exception    = o_Valid ? exc_mem_q[rd_ptr_q] : 1'b0;
    assign o_CacheAddress = pc_q;

    // Inflight fetches reserve a FIFO slot so a returning word always fits.
    assign pop       = o_Valid & i_Ready;
    assign push      = inflight_q & ~i_Redirect;
    assign occupancy = count_q + (AW + 1)'(inflight_q);
    assign issue     = (state_q == ST_FETCH) && !i_Redirect &&
                       ((occupancy < DEPTH_W) || ((occupancy == DEPTH_W) && pop));

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inflight_d       = inflight_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_fault_d = inflight_fault_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        pc_mem_d         = pc_mem_q;
        ins_mem_d        = ins_mem_q;
        exc_mem_d        = exc_mem_q;

        if (i_Redirect) begin
            state_d    = ST_FETCH;
            pc_d       = i_RedirectTarget;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]  = inflight_pc_q;
                ins_mem_d[wr_ptr_q] = inflight_fault_q ? 32'd0 : i_CacheData;
                exc_mem_d[wr_ptr_q] = inflight_fault_q;
                wr_ptr_d            = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d    = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d    = pc_q;
                inflight_fault_d = i_CacheAddressMisaligned;
                if (i_CacheAddressMisaligned) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q          <= ST_FETCH;
            pc_q             <= RESET_VECTOR;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= 32'd0;
            inflight_fault_q <= 1'b0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_fault_q <= inflight_fault_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge i_Clock) begin
        pc_mem_q  <= pc_mem_d;
        ins_mem_q <= ins_mem_d;
        exc_mem_q <= exc_mem_d;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset_n && push && !pop) begin
            assert (count_q != DEPTH_W);
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural cache (word k = k)
// and a queue of expected entries checked whenever decode accepts the head.
module tb_instruction_fetch;
    localparam logic [31:0] RV = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cache_addr;
    logic [31:0] cache_data;
    logic        cache_mis;
    logic        redir;
    logic [31:0] redir_tgt;
    logic        valid;
    logic        ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic        out_exc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_VECTOR(RV), .FIFO_DEPTH(2)) dut (
        .i_Clock                 (clk),
        .i_Reset_n               (rst_n),
        .o_CacheAddress          (cache_addr),
        .i_CacheData             (cache_data),
        .i_CacheAddressMisaligned(cache_mis),
        .i_Redirect              (redir),
        .i_RedirectTarget        (redir_tgt),
        .o_Valid                 (valid),
        .i_Ready                 (ready),
        .o_PC                    (out_pc),
        .o_Instruction           (out_ins),
        .o_Exception             (out_exc)
    );

    // Cache model: registered read of word addr>>2, combinational misalignment flag.
    always @(posedge clk) cache_data <= cache_addr >> 2;
    assign cache_mis = |cache_addr[1:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic load_stream(input logic [31:0] t);
        exp_q.delete();
        if (t[1:0] != 2'b00) begin
            exp_q.push_back('{t, 32'd0, 1'b1});
        end else begin
            for (int k = 0; k < 40; k++)
                exp_q.push_back('{t + 32'(4 * k), (t >> 2) + 32'(k), 1'b0});
        end
    endtask

    task automatic cycle();
        exp_t e;
        if (valid === 1'b1 && ready) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_empty observed pc=%h expected no entry", out_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_ins", out_ins, e.ins);
                chk("sb_exc", {31'd0, out_exc}, {31'd0, e.exc});
            end
        end
        if (!rst_n) load_stream(RV);
        else if (redir) load_stream(redir_tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] t, input logic rdy);
        redir     = 1'b1;
        redir_tgt = t;
        ready     = rdy;
        cycle();
        redir     = 1'b0;
        ready     = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ready     = 1'b1;
        redir     = 1'b0;
        redir_tgt = 32'd0;
        cycle();
        cycle();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_ins", out_ins, 32'd0);
        chk("rst_exc", {31'd0, out_exc}, 32'd0);
        chk("rst_addr", cache_addr, RV);

        // streaming from the reset vector
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("stream_addr", cache_addr, RV + 32'(4 * k));
            chk("stream_valid", {31'd0, valid}, (k >= 2) ? 32'd1 : 32'd0);
            cycle();
        end

        // backpressure: head holds, fetch stops at address 40
        ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk("bp_addr", cache_addr, 32'd40);
            chk("bp_valid", {31'd0, valid}, 32'd1);
            chk("bp_pc", out_pc, 32'd32);
            chk("bp_ins", out_ins, 32'd8);
            cycle();
        end
        ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk("bp_resume_valid", {31'd0, valid}, 32'd1);
            cycle();
        end

        // redirect while the FIFO is full and decode stalled
        ready = 1'b0;
        repeat (3) cycle();
        redirect_to(32'h100, 1'b0);
        chk("rf_r1_valid", {31'd0, valid}, 32'd0);
        chk("rf_r1_addr", cache_addr, 32'h100);
        cycle();
        chk("rf_r2_valid", {31'd0, valid}, 32'd0);
        cycle();
        chk("rf_r3_valid", {31'd0, valid}, 32'd1);
        chk("rf_r3_pc", out_pc, 32'h100);
        repeat (5) cycle();

        // misaligned redirect: single fault entry, then halt
        redirect_to(32'h102, 1'b1);
        chk("mis_r1_valid", {31'd0, valid}, 32'd0);
        chk("mis_r1_addr", cache_addr, 32'h102);
        cycle();
        chk("mis_r2_valid", {31'd0, valid}, 32'd0);
        cycle();
        chk("mis_r3_valid", {31'd0, valid}, 32'd1);
        chk("mis_r3_pc", out_pc, 32'h102);
        chk("mis_r3_exc", {31'd0, out_exc}, 32'd1);
        chk("mis_r3_ins", out_ins, 32'd0);
        cycle();
        for (int j = 0; j < 6; j++) begin
            chk("halt_valid", {31'd0, valid}, 32'd0);
            chk("halt_addr", cache_addr, 32'h102);
            cycle();
        end

        // recovery from halt
        redirect_to(32'h200, 1'b1);
        chk("rec_r1_addr", cache_addr, 32'h200);
        chk("rec_r1_valid", {31'd0, valid}, 32'd0);
        cycle();
        cycle();
        chk("rec_r3_valid", {31'd0, valid}, 32'd1);
        chk("rec_r3_pc", out_pc, 32'h200);
        repeat (4) cycle();

        // redirect coinciding with a pop
        chk("rp_pre_valid", {31'd0, valid}, 32'd1);
        redirect_to(32'h300, 1'b1);
        chk("rp_r1_valid", {31'd0, valid}, 32'd0);
        cycle();
        chk("rp_r2_valid", {31'd0, valid}, 32'd0);
        cycle();
        chk("rp_r3_pc", out_pc, 32'h300);
        chk("rp_r3_ins", out_ins, 32'hC0);
        repeat (4) cycle();

        // reset mid-stream with a full FIFO
        ready = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b0;
        cycle();
        chk("mrst_valid", {31'd0, valid}, 32'd0);
        chk("mrst_addr", cache_addr, RV);
        chk("mrst_pc", out_pc, 32'd0);
        rst_n = 1'b1;
        ready = 1'b1;
        cycle();
        chk("mrst_c1_valid", {31'd0, valid}, 32'd0);
        cycle();
        chk("mrst_c2_valid", {31'd0, valid}, 32'd1);
        chk("mrst_c2_pc", out_pc, RV);
        repeat (5) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly upstream of `instruction_cache`. It owns the program counter and drives the cache address every cycle. It tags each issued address so it can pair the cache's one-cycle-late read data with its PC, and buffers fetched words in a small FIFO toward decode using a valid/ready handshake. Branch/jump redirects flush all buffered and in-flight fetches, and misaligned fetches are delivered as a flagged entry.

## Interface
- `RESET_VECTOR`, default 32'h00000000: PC loaded on reset. Must be 4-byte aligned.
- `FIFO_DEPTH`, default 2: output buffer entries. Power of two, at least 2.

- `i_Clock`  in  1  sole clock, rising edge.
- `i_Reset_n`  in  1  synchronous, active-low reset.
- `o_CacheAddress`  out  32  byte address to the cache `i_Address`; always equals the fetch PC register.
- `i_CacheData`  in  32  cache `o_DataOut`; holds the word for the address driven in the previous cycle.
- `i_CacheAddressMisaligned`  in  1  cache `o_AddressMisaligned`; combinational on the current `o_CacheAddress`.
- `i_Redirect`  in  1  single-cycle pulse: flush and restart at `i_RedirectTarget`.
- `i_RedirectTarget`  in  32  new PC, sampled only when `i_Redirect`=1.
- `o_Valid`  out  1  FIFO head holds an entry.
- `i_Ready`  in  1  decode accepts the head. Pop = `o_Valid` & `i_Ready`.
- `o_PC`  out  32  PC of the head entry.
- `o_Instruction`  out  32  instruction word of the head entry.
- `o_Exception`  out  1  head entry is a misaligned-fetch fault. `o_Instruction` is 0 for such entries.

## Operation
- **State machine.** Two states: FETCH and HALT.
  - Reset enters FETCH.
  - An issue with `i_CacheAddressMisaligned`=1 moves FETCH to HALT.
  - `i_Redirect` moves HALT (or FETCH) to FETCH.
- **Issue.** An issue happens when the state is FETCH, `i_Redirect`=0, and one of these holds:
  - count + inflight < `FIFO_DEPTH`, or
  - count + inflight = `FIFO_DEPTH` and a pop occurs this cycle.
- **On issue:**
  - Set the inflight bit.
  - Capture inflight PC = fetch PC and inflight fault = `i_CacheAddressMisaligned`.
  - Fetch PC <= fetch PC + 4, with 32-bit wrap (0xFFFFFFFC + 4 = 0).
  - If the fault bit is 1, do not advance the PC and enter HALT.
- **Return.** In the cycle after an issue, with inflight=1 and no redirect, push {inflight PC, `i_CacheData` (0 if faulted), fault} into the FIFO and clear inflight, unless a new issue sets it again.
- **Non-issue cycles.** The cache still reads the driven address; that data is discarded because inflight is 0.
- **Simultaneous push and pop.** Both take effect; the count is unchanged. Overflow is impossible by construction, and an assertion checks it.
- **Redirect.** Has priority over everything else:
  - Clear FIFO and inflight.
  - Fetch PC <= `i_RedirectTarget`; state <= FETCH.
  - No issue and no push occur in the redirect cycle.
  - A pop in the same cycle counts as consumed by decode; the FIFO is cleared regardless.
- **HALT.** No issues. The FIFO drains normally; the fault entry is the last one delivered.
- **Reset** (`i_Reset_n`=0 at an edge): fetch PC = `RESET_VECTOR`, FIFO empty, inflight = 0, state FETCH. Reset mid-operation discards everything.

## Timing
- **Output values under reset:** `o_Valid`=0, `o_PC`=0, `o_Instruction`=0, `o_Exception`=0, `o_CacheAddress`=`RESET_VECTOR`.
- **Outputs are registered.** `o_Valid`, `o_PC`, `o_Instruction` and `o_Exception` come from FIFO storage. `o_CacheAddress` comes from the PC register.
- **Latency.** An address issued in cycle N has its data on `i_CacheData` in N+1, and the entry appears on `o_Valid` in N+2.
- **After reset release** (first cycle with `i_Reset_n`=1 is cycle 0): issue in cycle 0, `o_Valid`=1 with `o_PC`=`RESET_VECTOR` in cycle 2.
- **After a redirect in cycle R:** target on `o_CacheAddress` in R+1, first new entry valid in R+3. `o_Valid`=0 in cycles R+1 and R+2.
- **Throughput.** One instruction per cycle while `i_Ready`=1.
- **Handshake.** While `o_Valid`=1 and `i_Ready`=0, the head entry (`o_PC`, `o_Instruction`, `o_Exception`) holds stable.

## Test plan
- **Reset and streaming.** `RESET_VECTOR`=0, memory word k = k, `i_Ready`=1. Expect `o_CacheAddress` 0,4,8,… from cycle 0; `o_Valid` first in cycle 2 with `o_PC`=0, `o_Instruction`=0; then one entry per cycle with PC 4,8,… and no gaps.
- **Backpressure.** Drop `i_Ready` for 5 cycles mid-stream. Expect the head to hold stable, `o_CacheAddress` to stop advancing once count + inflight = 2, and no lost or duplicate PCs when `i_Ready` returns.
- **Redirect on a full FIFO.** `i_Redirect` with target 0x100 while `i_Ready`=0. Expect `o_Valid`=0 in R+1 and R+2, then `o_PC`=0x100 in R+3, and no stale entries.
- **Misaligned redirect.** Target 0x102. Expect exactly one entry with `o_PC`=0x102, `o_Exception`=1, `o_Instruction`=0, then `o_Valid`=0 indefinitely. A following redirect to 0x200 resumes normally with 0x200 at R+3.
- **Redirect and pop in the same cycle.** Expect the FIFO cleared and the popped entry not repeated.
- **Reset mid-stream.** Assert `i_Reset_n`=0 for one cycle with a full FIFO. Expect the next cycle to show `o_Valid`=0 and `o_CacheAddress`=`RESET_VECTOR`, and the stream to restart from the vector.
